d_victim_cache_swap_ctrl: RTL and testbench

- Controller on the L1-facing side of the data-cache victim cache.
- On an L1 miss it searches the fully associative VC tags and returns a hit line to L1. It accepts L1's evicted line, swapping it into the hit way or allocating a FIFO way.
- Dirty VC victims are written back to memory before being overwritten.
- Drives the VC data array's write-enable, way index and write data, and consumes its combinational read data.

---
 rtl/d_victim_cache_swap_ctrl_pkg.sv | 29 ++
 rtl/d_victim_cache_tag.sv | 63 ++++++
 rtl/d_victim_cache_swap_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_d_victim_cache_swap_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/d_victim_cache_swap_ctrl_pkg.sv
// Shared definitions for the data-cache victim cache: geometry, line and tag
// entry types, and the swap controller state encoding.
package cache_def;

    localparam int WAYS_VC      = 4;
    localparam int INDEX_WAY_VC = 2;
    localparam int ADDR_W       = 32;
    localparam int OFFSET_W     = 4;
    localparam int LINE_W       = 128;
    localparam int TAG_W        = ADDR_W - OFFSET_W;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } vc_tag_type;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        READ,
        WB,
        WRITE,
        RESP
    } vc_state_e;

endpackage

// File: rtl/d_victim_cache_tag.sv
// Victim cache tag store: per-way valid/dirty/tag, two fully associative
// match encoders (request tag and evicted-line tag), one indexed read port,
// one write port and one invalidate port.
import cache_def::*;

module d_victim_cache_tag (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic [TAG_W-1:0]        ev_tag,
    output logic                    req_hit,
    output logic [INDEX_WAY_VC-1:0] req_way,
    output logic                    ev_hit,
    output logic [INDEX_WAY_VC-1:0] ev_way,
    input  logic [INDEX_WAY_VC-1:0] rd_way,
    output vc_tag_type              rd_entry,
    input  logic                    wr_en,
    input  logic [INDEX_WAY_VC-1:0] wr_way,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic                    wr_dirty,
    input  logic                    inv_en,
    input  logic [INDEX_WAY_VC-1:0] inv_way
);

    vc_tag_type entries [WAYS_VC];

    // Tag array update: reset clears everything, write installs a valid line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS_VC; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (inv_en) begin
                entries[inv_way] <= '0;
            end
            if (wr_en) begin
                entries[wr_way] <= '{valid: 1'b1, dirty: wr_dirty, tag: wr_tag};
            end
        end
    end

    // Associative match; the controller guarantees at most one valid way per tag.
    always_comb begin
        req_hit = 1'b0;
        req_way = '0;
        ev_hit  = 1'b0;
        ev_way  = '0;
        for (int i = 0; i < WAYS_VC; i++) begin
            if (entries[i].valid && entries[i].tag == req_tag) begin
                req_hit = 1'b1;
                req_way = i[INDEX_WAY_VC-1:0];
            end
            if (entries[i].valid && entries[i].tag == ev_tag) begin
                ev_hit = 1'b1;
                ev_way = i[INDEX_WAY_VC-1:0];
            end
        end
    end

    assign rd_entry = entries[rd_way];

endmodule

// File: rtl/d_victim_cache_swap_ctrl.sv
// L1-facing victim cache swap controller. Looks up L1 misses in the victim
// cache, returns hit lines, swaps or FIFO-allocates the evicted L1 line and
// writes dirty victims back to memory first.
// Optional macro VC_STATS_EN adds saturating hit/miss/writeback counters.
//
// state  | meaning
// IDLE   | ready for an L1 miss request
// LOOKUP | compare request/evict tags, pick target way
// READ   | read hit line and dirty bit into response registers
// WB     | write dirty victim to memory, wait for ready
// WRITE  | write evicted L1 line into target way
// RESP   | one-cycle response pulse to L1
import cache_def::*;

module d_victim_cache_swap_ctrl #(
    parameter int WAYS_VC      = cache_def::WAYS_VC,
    parameter int INDEX_WAY_VC = cache_def::INDEX_WAY_VC,
    parameter int ADDR_W       = cache_def::ADDR_W,
    parameter int OFFSET_W     = cache_def::OFFSET_W,
    parameter int LINE_W       = cache_def::LINE_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    l1_req_valid_i,
    input  logic [ADDR_W-1:0]       l1_req_addr_i,
    input  logic                    l1_evict_valid_i,
    input  logic [ADDR_W-1:0]       l1_evict_addr_i,
    input  logic                    l1_evict_dirty_i,
    input  logic [LINE_W-1:0]       l1_evict_data_i,
    output logic                    l1_req_ready_o,
    output logic                    l1_resp_valid_o,
    output logic                    l1_resp_hit_o,
    output logic                    l1_resp_dirty_o,
    output logic [LINE_W-1:0]       l1_resp_data_o,
    output logic                    mem_wb_valid_o,
    input  logic                    mem_wb_ready_i,
    output logic [ADDR_W-1:0]       mem_wb_addr_o,
    output logic [LINE_W-1:0]       mem_wb_data_o,
    output logic                    vc_data_we_o,
    output logic [INDEX_WAY_VC-1:0] vc_way_o,
    output logic [LINE_W-1:0]       vc_data_wr_o,
    input  logic [LINE_W-1:0]       vc_data_rd_i
`ifdef VC_STATS_EN
    ,
    output logic [31:0]             stat_hit_o,
    output logic [31:0]             stat_miss_o,
    output logic [31:0]             stat_wb_o
`endif
);

    localparam int TW = ADDR_W - OFFSET_W;

    vc_state_e               state, state_nx;
    logic [TW-1:0]           req_tag_q, ev_tag_q, wb_tag_q;
    logic                    ev_valid_q, ev_dirty_q;
    logic [LINE_W-1:0]       ev_data_q, resp_data_q, wb_data_q;
    logic [INDEX_WAY_VC-1:0] way_q, fifo_ptr, rd_way;
    logic                    alloc_q, upd_q, hit_q, resp_dirty_q;

    logic                    req_hit, ev_hit;
    logic [INDEX_WAY_VC-1:0] req_way, ev_way;
    vc_tag_type              rd_entry;
    logic                    wr_en, wr_dirty, inv_en;
    logic                    victim_dirty;

    d_victim_cache_tag u_tag (
        .clk      (clk_i),
        .rst      (rst_i),
        .req_tag  (req_tag_q),
        .ev_tag   (ev_tag_q),
        .req_hit  (req_hit),
        .req_way  (req_way),
        .ev_hit   (ev_hit),
        .ev_way   (ev_way),
        .rd_way   (rd_way),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_way   (way_q),
        .wr_tag   (ev_tag_q),
        .wr_dirty (wr_dirty),
        .inv_en   (inv_en),
        .inv_way  (way_q)
    );

    // During LOOKUP the tag read port looks at the FIFO victim; later it follows the target way.
    assign rd_way       = (state == LOOKUP) ? fifo_ptr : way_q;
    assign victim_dirty = rd_entry.valid & rd_entry.dirty;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx        = state;
        l1_req_ready_o  = 1'b0;
        l1_resp_valid_o = 1'b0;
        l1_resp_hit_o   = 1'b0;
        l1_resp_dirty_o = 1'b0;
        l1_resp_data_o  = '0;
        mem_wb_valid_o  = 1'b0;
        mem_wb_addr_o   = '0;
        mem_wb_data_o   = '0;
        vc_data_we_o    = 1'b0;
        vc_way_o        = '0;
        vc_data_wr_o    = '0;
        wr_en           = 1'b0;
        wr_dirty        = 1'b0;
        inv_en          = 1'b0;
        case (state)
            IDLE: begin
                l1_req_ready_o = 1'b1;
                if (l1_req_valid_i) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                vc_way_o = fifo_ptr;
                if (req_hit) begin
                    state_nx = READ;
                end else if (!ev_valid_q) begin
                    state_nx = RESP;
                end else if (!ev_hit && victim_dirty) begin
                    state_nx = WB;
                end else begin
                    state_nx = WRITE;
                end
            end
            READ: begin
                vc_way_o = way_q;
                if (ev_valid_q) begin
                    state_nx = WRITE;
                end else begin
                    inv_en   = 1'b1;
                    state_nx = RESP;
                end
            end
            WB: begin
                mem_wb_valid_o = 1'b1;
                mem_wb_addr_o  = {wb_tag_q, {OFFSET_W{1'b0}}};
                mem_wb_data_o  = wb_data_q;
                if (mem_wb_ready_i) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                vc_data_we_o = 1'b1;
                vc_way_o     = way_q;
                vc_data_wr_o = ev_data_q;
                wr_en        = 1'b1;
                // Update-in-place must not lose dirtiness already held in the VC.
                wr_dirty     = ev_dirty_q | (upd_q & rd_entry.dirty);
                state_nx     = RESP;
            end
            RESP: begin
                l1_resp_valid_o = 1'b1;
                l1_resp_hit_o   = hit_q;
                l1_resp_dirty_o = resp_dirty_q;
                l1_resp_data_o  = resp_data_q;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, way selection, response/writeback latches and FIFO pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_tag_q    <= '0;
            ev_tag_q     <= '0;
            ev_valid_q   <= 1'b0;
            ev_dirty_q   <= 1'b0;
            ev_data_q    <= '0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
            resp_data_q  <= '0;
            resp_dirty_q <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            alloc_q      <= 1'b0;
            upd_q        <= 1'b0;
            fifo_ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (l1_req_valid_i) begin
                        req_tag_q    <= l1_req_addr_i[ADDR_W-1:OFFSET_W];
                        ev_tag_q     <= l1_evict_addr_i[ADDR_W-1:OFFSET_W];
                        ev_valid_q   <= l1_evict_valid_i;
                        ev_dirty_q   <= l1_evict_dirty_i;
                        ev_data_q    <= l1_evict_data_i;
                        resp_data_q  <= '0;
                        resp_dirty_q <= 1'b0;
                        hit_q        <= 1'b0;
                        alloc_q      <= 1'b0;
                        upd_q        <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (req_hit) begin
                        way_q <= req_way;
                    end else if (ev_valid_q) begin
                        if (ev_hit) begin
                            way_q <= ev_way;
                            upd_q <= 1'b1;
                        end else begin
                            way_q   <= fifo_ptr;
                            alloc_q <= 1'b1;
                            if (victim_dirty) begin
                                wb_tag_q  <= rd_entry.tag;
                                wb_data_q <= vc_data_rd_i;
                            end
                        end
                    end
                end
                READ: begin
                    hit_q        <= 1'b1;
                    resp_dirty_q <= rd_entry.dirty;
                    resp_data_q  <= vc_data_rd_i;
                end
                WRITE: begin
                    if (alloc_q) begin
                        fifo_ptr <= fifo_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VC_STATS_EN
    // Saturating lookup and writeback counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit_o  <= '0;
            stat_miss_o <= '0;
            stat_wb_o   <= '0;
        end else begin
            if (state == LOOKUP && req_hit && stat_hit_o != '1) begin
                stat_hit_o <= stat_hit_o + 32'd1;
            end
            if (state == LOOKUP && !req_hit && stat_miss_o != '1) begin
                stat_miss_o <= stat_miss_o + 32'd1;
            end
            if (state == WB && mem_wb_ready_i && stat_wb_o != '1) begin
                stat_wb_o <= stat_wb_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_d_victim_cache_swap_ctrl.sv
// Bench for the victim cache swap controller: table of request vectors with
// a response scoreboard, plus a hand-written reset-during-writeback sequence.
module tb_d_victim_cache_swap_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         ev_valid;
    logic [31:0]  ev_addr;
    logic         ev_dirty;
    logic [127:0] ev_data;
    logic         req_ready;
    logic         resp_valid, resp_hit, resp_dirty;
    logic [127:0] resp_data;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         we;
    logic [1:0]   vc_way;
    logic [127:0] vc_wr, vc_rd;
    logic [127:0] vc_mem [4];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0]  req_addr;
        logic         ev_valid;
        logic [31:0]  ev_addr;
        logic         ev_dirty;
        logic [127:0] ev_data;
        logic         exp_hit;
        logic         exp_dirty;
        logic [127:0] exp_data;
        logic         exp_we;
        logic [1:0]   exp_way;
        logic         exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        int           stall;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic         hit;
        logic         dirty;
        logic [127:0] data;
    } resp_t;

    vec_t  vecs [15];
    resp_t sb_q [$];

    always #5 clk = ~clk;

    d_victim_cache_swap_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .l1_req_valid_i   (req_valid),
        .l1_req_addr_i    (req_addr),
        .l1_evict_valid_i (ev_valid),
        .l1_evict_addr_i  (ev_addr),
        .l1_evict_dirty_i (ev_dirty),
        .l1_evict_data_i  (ev_data),
        .l1_req_ready_o   (req_ready),
        .l1_resp_valid_o  (resp_valid),
        .l1_resp_hit_o    (resp_hit),
        .l1_resp_dirty_o  (resp_dirty),
        .l1_resp_data_o   (resp_data),
        .mem_wb_valid_o   (wb_valid),
        .mem_wb_ready_i   (wb_ready),
        .mem_wb_addr_o    (wb_addr),
        .mem_wb_data_o    (wb_data),
        .vc_data_we_o     (we),
        .vc_way_o         (vc_way),
        .vc_data_wr_o     (vc_wr),
        .vc_data_rd_i     (vc_rd)
    );

    // Data array model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (we) vc_mem[vc_way] <= vc_wr;
    end
    assign vc_rd = vc_mem[vc_way];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dl(input logic [31:0] x);
        return {4{x}};
    endfunction

    function automatic vec_t mkv(
        input logic [31:0] ra, input logic evv, input logic [31:0] eva, input logic evd,
        input logic [127:0] evdat, input logic h, input logic d, input logic [127:0] dat,
        input logic w, input logic [1:0] wy, input logic wb, input logic [31:0] wba,
        input logic [127:0] wbd, input int st, input int lat);
        vec_t v;
        v.req_addr = ra;  v.ev_valid = evv; v.ev_addr = eva; v.ev_dirty = evd;
        v.ev_data = evdat; v.exp_hit = h; v.exp_dirty = d; v.exp_data = dat;
        v.exp_we = w; v.exp_way = wy; v.exp_wb = wb; v.exp_wb_addr = wba;
        v.exp_wb_data = wbd; v.stall = st; v.exp_lat = lat;
        return v;
    endfunction

    // Scoreboard: every response pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_unexpected: got response with empty scoreboard, expected none");
            end else begin
                resp_t r;
                r = sb_q.pop_front();
                chk("resp_hit", {127'd0, resp_hit}, {127'd0, r.hit});
                chk("resp_dirty", {127'd0, resp_dirty}, {127'd0, r.dirty});
                chk("resp_data", resp_data, r.data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {127'd0, req_ready}, 128'd1);
        chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("rst_we", {127'd0, we}, 128'd0);
        chk("rst_way", {126'd0, vc_way}, 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int    cyc, lat, wb_cyc, n_we;
        resp_t r;
        @(negedge clk);
        req_addr  = v.req_addr;
        ev_valid  = v.ev_valid;
        ev_addr   = v.ev_addr;
        ev_dirty  = v.ev_dirty;
        ev_data   = v.ev_data;
        req_valid = 1'b1;
        chk({tag, "_ready"}, {127'd0, req_ready}, 128'd1);
        r.hit = v.exp_hit; r.dirty = v.exp_dirty; r.data = v.exp_data;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ev_valid  = 1'b0;
        cyc = 0; lat = -1; wb_cyc = 0; n_we = 0;
        while (lat < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (we) begin
                n_we++;
                chk({tag, "_we_way"}, {126'd0, vc_way}, {126'd0, v.exp_way});
                chk({tag, "_we_data"}, vc_wr, v.ev_data);
            end
            if (wb_valid) begin
                chk({tag, "_wb_addr"}, {96'd0, wb_addr}, {96'd0, v.exp_wb_addr});
                chk({tag, "_wb_data"}, wb_data, v.exp_wb_data);
                if (wb_cyc == v.stall) wb_ready = 1'b1;
                wb_cyc++;
            end else begin
                wb_ready = 1'b0;
            end
            if (resp_valid) lat = cyc;
        end
        wb_ready = 1'b0;
        chk({tag, "_latency"}, 128'(lat), 128'(v.exp_lat));
        chk({tag, "_we_count"}, 128'(n_we), {127'd0, v.exp_we});
        chk({tag, "_wb_cycles"}, 128'(wb_cyc), v.exp_wb ? 128'(v.stall + 1) : 128'd0);
    endtask

    initial begin
        logic [127:0] a5;
        int           waited;
        a5 = {16{8'hA5}};
        for (int i = 0; i < 4; i++) vc_mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; ev_valid = 1'b0;
        ev_addr = '0; ev_dirty = 1'b0; ev_data = '0; wb_ready = 1'b0;

        vecs[0]  = mkv(32'h1000, 0, 32'h0,   0, '0,      0, 0, '0,      0, 2'd0, 0, 32'h0,   '0,      0, 2);
        vecs[1]  = mkv(32'h1000, 1, 32'h2000,0, a5,      0, 0, '0,      1, 2'd0, 0, 32'h0,   '0,      0, 3);
        vecs[2]  = mkv(32'h2000, 0, 32'h0,   0, '0,      1, 0, a5,      0, 2'd0, 0, 32'h0,   '0,      0, 3);
        vecs[3]  = mkv(32'h2000, 0, 32'h0,   0, '0,      0, 0, '0,      0, 2'd0, 0, 32'h0,   '0,      0, 2);
        vecs[4]  = mkv(32'h9000, 1, 32'h100, 1, dl(32'hD1), 0, 0, '0,   1, 2'd0, 0, 32'h0,   '0,      0, 3);
        vecs[5]  = mkv(32'h9000, 1, 32'h200, 0, dl(32'hD2), 0, 0, '0,   1, 2'd1, 0, 32'h0,   '0,      0, 3);
        vecs[6]  = mkv(32'h9000, 1, 32'h300, 1, dl(32'hD3), 0, 0, '0,   1, 2'd2, 0, 32'h0,   '0,      0, 3);
        vecs[7]  = mkv(32'h9000, 1, 32'h400, 1, dl(32'hD4), 0, 0, '0,   1, 2'd3, 0, 32'h0,   '0,      0, 3);
        vecs[8]  = mkv(32'h900,  1, 32'h500, 1, dl(32'hD5), 0, 0, '0,   1, 2'd0, 1, 32'h100, dl(32'hD1), 5, 9);
        vecs[9]  = mkv(32'h300,  1, 32'h600, 1, dl(32'hD6), 1, 1, dl(32'hD3), 1, 2'd2, 0, 32'h0, '0, 0, 4);
        vecs[10] = mkv(32'h9000, 1, 32'h200, 1, dl(32'hD7), 0, 0, '0,   1, 2'd1, 0, 32'h0,   '0,      0, 3);
        vecs[11] = mkv(32'h9000, 1, 32'h700, 0, dl(32'hD8), 0, 0, '0,   1, 2'd1, 1, 32'h200, dl(32'hD7), 0, 4);
        vecs[12] = mkv(32'h600,  0, 32'h0,   0, '0,      1, 1, dl(32'hD6), 0, 2'd0, 0, 32'h0, '0,      0, 3);
        vecs[13] = mkv(32'h500,  0, 32'h0,   0, '0,      1, 1, dl(32'hD5), 0, 2'd0, 0, 32'h0, '0,      0, 3);
        vecs[14] = mkv(32'h9000, 1, 32'h800, 1, dl(32'hD9), 0, 0, '0,   1, 2'd2, 0, 32'h0,   '0,      0, 3);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i == 4) do_reset();
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while stalled in writeback: way 3 holds dirty 0x400 and is the FIFO victim.
        @(negedge clk);
        req_addr = 32'h9000; ev_valid = 1'b1; ev_addr = 32'hA00; ev_dirty = 1'b0;
        ev_data = dl(32'hDA); req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; ev_valid = 1'b0;
        waited = 0;
        while (!wb_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_wb_seen", {127'd0, wb_valid}, 128'd1);
        chk("abort_wb_addr", {96'd0, wb_addr}, 128'h400);
        chk("abort_wb_data", wb_data, dl(32'hD4));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_wb_valid", {127'd0, wb_valid}, 128'd0);
        chk("abort_ready", {127'd0, req_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mkv(32'h400, 0, 32'h0, 0, '0, 0, 0, '0, 0, 2'd0, 0, 32'h0, '0, 0, 2), "post_rst_400");
        run_vec(mkv(32'h800, 0, 32'h0, 0, '0, 0, 0, '0, 0, 2'd0, 0, 32'h0, '0, 0, 2), "post_rst_800");

        repeat (2) @(negedge clk);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
